// File: rtl/bnn_ctrl_pkg.sv
// Shared types for the BNN command controller: FSM state encoding, default command codes, error bits.
// Pure declarations; no timing or flow-control behaviour lives here.
package bnn_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RX_CMD   = 4'd1,
        ST_DISPATCH = 4'd2,
        ST_STATUS   = 4'd3,
        ST_IMG_RX   = 4'd4,
        ST_WAIT_INF = 4'd5,
        ST_RESULT   = 4'd6,
        ST_CLEAR    = 4'd7
    } state_e;

    localparam logic [7:0] DEF_CMD_STATUS = 8'hFE;
    localparam logic [7:0] DEF_CMD_IMG_TX = 8'hBF;
    localparam logic [7:0] DEF_CMD_RESULT = 8'hA5;
    localparam logic [7:0] DEF_CMD_CLEAR  = 8'hC3;

    localparam int ERR_W        = 3;
    localparam int ERR_TIMEOUT  = 0;
    localparam int ERR_UNKNOWN  = 1;
    localparam int ERR_OVERFLOW = 2;

    function automatic logic [7:0] status_byte(input logic busy_prev,
                                               input logic result_valid,
                                               input logic [ERR_W-1:0] err);
        return {busy_prev, result_valid, 1'b0, err, 2'b01};
    endfunction

endpackage

// File: rtl/bnn_cmd_ctrl_v2_sync_edge.sv
// Multi-flop synchroniser for one async level, with registered rise/fall pulses.
// Latency SYNC_STAGES to the level, one more to the edge pulses; no backpressure.
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stage_q, stage_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    always_comb begin
        stage_d = {stage_q[SYNC_STAGES-2:0], async_in};
        prev_d  = stage_q[SYNC_STAGES-1];
        rise_d  = stage_q[SYNC_STAGES-1] & ~prev_q;
        fall_d  = ~stage_q[SYNC_STAGES-1] & prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= {SYNC_STAGES{RST_VAL}};
            prev_q  <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            stage_q <= stage_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sync_out = stage_q[SYNC_STAGES-1];
    assign rise     = rise_q;
    assign fall     = fall_q;

endmodule

// File: rtl/bnn_cmd_ctrl_v2.sv
// SPI command decoder / image streamer / BNN inference sequencer with status, result and clear commands.
// Bytes are consumed SYNC_STAGES+1 clocks after byte_valid rises; a full image buffer drops writes and flags overflow.
module bnn_cmd_ctrl_v2 import bnn_ctrl_pkg::*; #(
    parameter int         IMG_BYTES      = 113,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         RESULT_W       = 4,
    parameter int         SYNC_STAGES    = 2,
    parameter logic [7:0] CMD_STATUS     = DEF_CMD_STATUS,
    parameter logic [7:0] CMD_IMG_TX     = DEF_CMD_IMG_TX,
    parameter logic [7:0] CMD_RESULT     = DEF_CMD_RESULT,
    parameter logic [7:0] CMD_CLEAR      = DEF_CMD_CLEAR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                spi_cs_n,
    input  logic [7:0]          spi_rx_data,
    input  logic                spi_byte_valid,
    output logic                byte_taken,
    output logic                rx_enable,
    output logic [7:0]          tx_data,
    output logic                tx_load,
    input  logic                buffer_full,
    input  logic                buffer_empty,
    output logic                buffer_write_enable,
    output logic                clear_buffer,
    input  logic                result_ready,
    input  logic [RESULT_W-1:0] result_out,
    output logic                bnn_start,
    output logic                busy,
    output logic [ERR_W-1:0]    err_flags,
    output logic [3:0]          fsm_state
);

    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
    localparam logic [9:0]       IMG_LAST = 10'(IMG_BYTES - 1);

    logic cs_s, cs_rise, cs_fall;
    logic vld_s, byte_edge, vld_fall;
    logic empty_s, empty_rise, empty_fall;
    logic res_rdy_s, res_rise, res_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .async_in(spi_cs_n),
        .sync_out(cs_s), .rise(cs_rise), .fall(cs_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_vld (
        .clk(clk), .rst(rst), .async_in(spi_byte_valid),
        .sync_out(vld_s), .rise(byte_edge), .fall(vld_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_empty (
        .clk(clk), .rst(rst), .async_in(buffer_empty),
        .sync_out(empty_s), .rise(empty_rise), .fall(empty_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_res (
        .clk(clk), .rst(rst), .async_in(result_ready),
        .sync_out(res_rdy_s), .rise(res_rise), .fall(res_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{cs_s, vld_s, vld_fall, empty_rise, empty_fall, res_rise, res_fall};

    state_e                state_q, state_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [9:0]            img_cnt_q, img_cnt_d;
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic [ERR_W-1:0]      err_q, err_d;
    logic [RESULT_W-1:0]   result_q, result_d;
    logic                  rvalid_q, rvalid_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  busy_q, busy_d;
    logic                  counting, timeout_hit;
    logic [7:0]            res_byte;

    always_comb begin
        state_d             = state_q;
        cmd_d               = cmd_q;
        img_cnt_d           = img_cnt_q;
        err_d               = err_q;
        result_d            = result_q;
        rvalid_d            = rvalid_q;
        tx_data_d           = tx_data_q;
        byte_taken          = 1'b0;
        buffer_write_enable = 1'b0;
        tx_load             = 1'b0;
        clear_buffer        = 1'b0;
        bnn_start           = 1'b0;
        rx_enable           = 1'b0;

        res_byte                = '0;
        res_byte[RESULT_W-1:0]  = result_q;
        res_byte[7]             = rvalid_q;

        counting    = (state_q == ST_RX_CMD) || (state_q == ST_IMG_RX);
        timeout_hit = counting && !byte_edge && (tmo_cnt_q == TMO_LIM);

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) state_d = ST_RX_CMD;
            end
            ST_RX_CMD: begin
                rx_enable = 1'b1;
                if (byte_edge) begin
                    byte_taken = 1'b1;
                    cmd_d      = spi_rx_data;
                end
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end else if (byte_edge) begin
                    state_d = ST_DISPATCH;
                end else if (timeout_hit) begin
                    err_d[ERR_TIMEOUT] = 1'b1;
                    state_d            = ST_IDLE;
                end
            end
            ST_DISPATCH: begin
                // Reply bytes are staged here so tx_data is already stable when tx_load pulses.
                case (cmd_q)
                    CMD_STATUS: begin
                        tx_data_d = status_byte(busy_q, rvalid_q, err_q);
                        state_d   = ST_STATUS;
                    end
                    CMD_IMG_TX: begin
                        img_cnt_d = '0;
                        rvalid_d  = 1'b0;
                        state_d   = ST_IMG_RX;
                    end
                    CMD_RESULT: begin
                        tx_data_d = res_byte;
                        state_d   = ST_RESULT;
                    end
                    CMD_CLEAR: begin
                        err_d   = '0;
                        state_d = ST_CLEAR;
                    end
                    default: begin
                        err_d[ERR_UNKNOWN] = 1'b1;
                        state_d            = ST_IDLE;
                    end
                endcase
            end
            ST_STATUS: begin
                tx_load = 1'b1;
                state_d = ST_IDLE;
            end
            ST_RESULT: begin
                tx_load  = 1'b1;
                rvalid_d = 1'b0;
                state_d  = ST_IDLE;
            end
            ST_IMG_RX: begin
                rx_enable = 1'b1;
                if (byte_edge) begin
                    byte_taken = 1'b1;
                    img_cnt_d  = img_cnt_q + 10'd1;
                    if (buffer_full) err_d[ERR_OVERFLOW] = 1'b1;
                    else             buffer_write_enable = 1'b1;
                end
                // A simultaneous cs_rise still consumes the byte above but aborts the transfer.
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end else if (byte_edge && (img_cnt_q == IMG_LAST)) begin
                    state_d = ST_WAIT_INF;
                end else if (timeout_hit) begin
                    err_d[ERR_TIMEOUT] = 1'b1;
                    state_d            = ST_IDLE;
                end
            end
            ST_WAIT_INF: begin
                bnn_start = 1'b1;
                if (res_rdy_s) begin
                    result_d = result_out;
                    rvalid_d = 1'b1;
                    state_d  = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clear_buffer = 1'b1;
                if (empty_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_d != state_q) || byte_edge) tmo_cnt_d = '0;
        else if (counting && (tmo_cnt_q != TMO_LIM)) tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        else tmo_cnt_d = tmo_cnt_q;

        busy_d = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            img_cnt_q <= '0;
            tmo_cnt_q <= '0;
            err_q     <= '0;
            result_q  <= '0;
            rvalid_q  <= 1'b0;
            tx_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            img_cnt_q <= img_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
            result_q  <= result_d;
            rvalid_q  <= rvalid_d;
            tx_data_q <= tx_data_d;
            busy_q    <= busy_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign tx_data   = tx_data_q;
    assign err_flags = err_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_bnn_cmd_ctrl_v2.sv
// Directed bench for bnn_cmd_ctrl_v2: status, image stream, inference/result, errors, timeout, overflow, reset.
// Inputs driven on the falling edge; strobes counted on the rising edge.
module tb_bnn_cmd_ctrl_v2;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_cs_n;
    logic [7:0] spi_rx_data;
    logic       spi_byte_valid;
    logic       byte_taken;
    logic       rx_enable;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       buffer_full;
    logic       buffer_empty;
    logic       buffer_write_enable;
    logic       clear_buffer;
    logic       result_ready;
    logic [3:0] result_out;
    logic       bnn_start;
    logic       busy;
    logic [2:0] err_flags;
    logic [3:0] fsm_state;

    always #5 clk = ~clk;

    bnn_cmd_ctrl_v2 #(
        .IMG_BYTES(113), .TIMEOUT_CYCLES(64), .RESULT_W(4), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_rx_data(spi_rx_data),
        .spi_byte_valid(spi_byte_valid), .byte_taken(byte_taken), .rx_enable(rx_enable),
        .tx_data(tx_data), .tx_load(tx_load), .buffer_full(buffer_full),
        .buffer_empty(buffer_empty), .buffer_write_enable(buffer_write_enable),
        .clear_buffer(clear_buffer), .result_ready(result_ready), .result_out(result_out),
        .bnn_start(bnn_start), .busy(busy), .err_flags(err_flags), .fsm_state(fsm_state)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    int         cyc_no = 0, wr_cnt = 0, bt_cnt = 0, txl_cnt = 0;
    int         wr_last = 0, bt_last = 0, bs_rise = -1;
    logic       bs_prev = 1'b0;
    logic [7:0] tx_last = 8'h00;

    always @(posedge clk) begin
        cyc_no++;
        if (buffer_write_enable) begin wr_cnt++; wr_last = cyc_no; end
        if (byte_taken)          begin bt_cnt++; bt_last = cyc_no; end
        if (tx_load)             begin txl_cnt++; tx_last = tx_data; end
        if (bnn_start && !bs_prev) bs_rise = cyc_no;
        bs_prev = bnn_start;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        spi_rx_data    = b;
        spi_byte_valid = 1'b1;
        cyc(4);
        spi_byte_valid = 1'b0;
        cyc(4);
    endtask

    task automatic cs_low;
        spi_cs_n = 1'b0;
        cyc(5);
    endtask

    task automatic cs_high;
        spi_cs_n = 1'b1;
        cyc(5);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        cs_low();
        send_byte(b);
    endtask

    int t_wr, t_bt, t_tx, lat;

    initial begin
        rst = 1'b1; spi_cs_n = 1'b1; spi_rx_data = 8'h00; spi_byte_valid = 1'b0;
        buffer_full = 1'b0; buffer_empty = 1'b0; result_ready = 1'b0; result_out = 4'd0;
        cyc(3);
        check("rst_state", fsm_state, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_err", err_flags, 0);
        check("rst_strobes", {rx_enable, tx_load, byte_taken, buffer_write_enable, bnn_start, clear_buffer}, 0);
        rst = 1'b0;
        cyc(2);

        // Status request: latency from byte_valid to tx_load
        cs_low();
        check("rx_cmd_state", fsm_state, 1);
        check("rx_cmd_rx_en", rx_enable, 1);
        t_tx = txl_cnt;
        spi_rx_data = 8'hFE; spi_byte_valid = 1'b1; lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (tx_load && lat == 0) begin
                lat = i;
                check("status_lo", tx_data[1:0], 2'b01);
                check("status_err", tx_data[4:2], 3'b000);
            end
        end
        check("status_lat", lat, SYNC + 3);
        spi_byte_valid = 1'b0;
        cyc(4);
        check("status_one_load", txl_cnt - t_tx, 1);
        check("status_idle", fsm_state, 0);
        cs_high();

        // Full image transfer
        t_wr = wr_cnt; t_bt = bt_cnt;
        send_cmd(8'hBF);
        check("img_rx_state", fsm_state, 4);
        for (int i = 0; i < 113; i++) begin
            send_byte(8'(i));
            if (i == 111) check("img_still_rx", fsm_state, 4);
        end
        check("img_wait_state", fsm_state, 5);
        check("img_bnn_start", bnn_start, 1);
        check("img_writes", wr_cnt - t_wr, 113);
        check("img_taken", bt_cnt - t_bt, 114);
        check("img_start_after_wr", bs_rise - wr_last, 1);
        check("img_no_clear", clear_buffer, 0);

        // Inference completes, buffer clear handshake
        result_out = 4'd7; result_ready = 1'b1;
        cyc(5);
        check("inf_clear_state", fsm_state, 7);
        check("inf_clear_on", clear_buffer, 1);
        result_ready = 1'b0;
        cyc(6);
        check("clear_hold", clear_buffer, 1);
        buffer_empty = 1'b1;
        cyc(5);
        check("clear_done_state", fsm_state, 0);
        check("clear_done_off", clear_buffer, 0);
        buffer_empty = 1'b0;
        cyc(3);
        cs_high();

        // Result read-back twice
        send_cmd(8'hA5);
        check("result_first", tx_last, 8'h87);
        cs_high();
        send_cmd(8'hA5);
        check("result_second", tx_last, 8'h07);
        cs_high();

        // Unknown command, status reflects it, then clear
        send_cmd(8'h12);
        check("unk_err", err_flags, 3'b010);
        check("unk_idle", fsm_state, 0);
        cs_high();
        send_cmd(8'hFE);
        check("unk_status", tx_last[4:0], 5'b01001);
        cs_high();
        buffer_empty = 1'b1;
        send_cmd(8'hC3);
        check("clr_err", err_flags, 0);
        check("clr_idle", fsm_state, 0);
        buffer_empty = 1'b0;
        cs_high();

        // Timeout after 50 bytes
        t_wr = wr_cnt;
        send_cmd(8'hBF);
        for (int i = 0; i < 50; i++) send_byte(8'(i + 3));
        check("tmo_writes", wr_cnt - t_wr, 50);
        for (int i = 0; i < 100 && fsm_state != 4'd0; i++) @(negedge clk);
        check("tmo_cycles", cyc_no - bt_last, 64);
        check("tmo_idle", fsm_state, 0);
        check("tmo_err", err_flags, 3'b001);
        cs_high();
        buffer_empty = 1'b1;
        send_cmd(8'hC3);
        buffer_empty = 1'b0;
        check("tmo_cleared", err_flags, 0);
        cs_high();

        // cs abort after 50 bytes: no error
        send_cmd(8'hBF);
        for (int i = 0; i < 50; i++) send_byte(8'(i));
        check("abort_in_rx", fsm_state, 4);
        cs_high();
        check("abort_idle", fsm_state, 0);
        check("abort_no_err", err_flags, 0);

        // Overflow after 10 bytes, then reset mid-stream
        t_wr = wr_cnt;
        send_cmd(8'hBF);
        for (int i = 0; i < 10; i++) send_byte(8'(i));
        buffer_full = 1'b1;
        t_bt = bt_cnt;
        for (int i = 0; i < 5; i++) send_byte(8'(i));
        check("ovf_writes", wr_cnt - t_wr, 10);
        check("ovf_taken", bt_cnt - t_bt, 5);
        check("ovf_err", err_flags, 3'b100);
        check("ovf_state", fsm_state, 4);
        spi_byte_valid = 1'b1;
        rst = 1'b1;
        cyc(1);
        check("mid_rst_state", fsm_state, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err_flags, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_strobes", {rx_enable, tx_load, byte_taken, buffer_write_enable, bnn_start, clear_buffer}, 0);
        rst = 1'b0; spi_byte_valid = 1'b0; buffer_full = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bnn_cmd_ctrl_v2.md
Name: bnn_cmd_ctrl_v2

Overview:
Parametrised successor to the OCR command/control FSM. It decodes SPI command bytes and streams a configurable-size image into the image buffer. It also sequences BNN inference and adds features the first generation lacks: a result read-back command, a host abort/clear command, and sticky error reporting with a status byte loaded back to the SPI transmitter. It sits between the SPI slave, the image buffer and the BNN core.

Parameters:
IMG_BYTES, 113, image payload bytes per IMG_TX command (1..1023)
TIMEOUT_CYCLES, 100000, idle clocks allowed between received bytes before abort
RESULT_W, 4, width of BNN class result
SYNC_STAGES, 2, flops in each input synchroniser (>=2)
CMD_STATUS, 8'hFE, status request code
CMD_IMG_TX, 8'hBF, image transfer code
CMD_RESULT, 8'hA5, result read-back code
CMD_CLEAR, 8'hC3, abort/clear code

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
spi_cs_n  in  1  SPI chip select, async, active-low
spi_rx_data  in  8  received byte; stable while spi_byte_valid is high
spi_byte_valid  in  1  async byte-valid level; each rising edge after sync means one new byte
byte_taken  out  1  one-cycle pulse when a byte is consumed
rx_enable  out  1  high while in RX_CMD or IMG_RX
tx_data  out  8  byte for the SPI transmitter
tx_load  out  1  one-cycle pulse; SPI TX latches tx_data
buffer_full  in  1  image buffer full
buffer_empty  in  1  image buffer empty, async
buffer_write_enable  out  1  one-cycle write strobe, data = spi_rx_data
clear_buffer  out  1  held while clearing
result_ready  in  1  BNN result valid, async level
result_out  in  RESULT_W  BNN class
bnn_start  out  1  held during WAIT_INF
busy  out  1  high in every state except IDLE
err_flags  out  3  sticky: [0] timeout, [1] unknown cmd, [2] overflow (write while full)
fsm_state  out  4  current state encoding

Behaviour:
- Reset: state IDLE. All strobes, rx_enable, bnn_start, clear_buffer, busy, tx_load = 0. tx_data = 0, err_flags = 0. Synchroniser flops: cs = 1, all others 0.
- Sync: spi_cs_n, spi_byte_valid, buffer_empty and result_ready each pass through SYNC_STAGES flops.
- byte_edge = synced valid & ~previous synced valid. cs_fall and cs_rise are edges of synced cs.
- IDLE: on cs_fall go to RX_CMD.
- RX_CMD: on byte_edge, pulse byte_taken and register the byte, then go to DISPATCH. On timeout, set err[0] and go to IDLE. On cs_rise, go to IDLE (no error).
- DISPATCH (1 cycle):
  - STATUS: go to STATUS.
  - IMG_TX: clear byte counter, go to IMG_RX.
  - RESULT: go to RESULT.
  - CLEAR: clear err_flags, go to CLEAR.
  - Any other code: set err[1], go to IDLE.
- STATUS (1 cycle): tx_data = {busy_prev, result_valid, 1'b0, err_flags, 2'b01}, pulse tx_load, go to IDLE.
- IMG_RX, on each byte_edge:
  - Pulse byte_taken.
  - If !buffer_full: pulse buffer_write_enable and increment the 10-bit counter.
  - If buffer_full: set err[2], no write, counter still increments.
  - When counter reaches IMG_BYTES-1 together with a byte_edge, the next state is WAIT_INF.
  - Abort to IDLE on cs_rise or timeout (timeout also sets err[0]).
  - If byte_edge and cs_rise occur in the same cycle, the byte is taken first and the abort wins the state change.
- Timeout counter: resets on every byte_edge and on state entry. Counts only in RX_CMD and IMG_RX. Saturates; no wrap.
- WAIT_INF: bnn_start = 1. When synced result_ready is seen, latch result_out into result_reg, set result_valid, go to CLEAR.
- CLEAR: clear_buffer = 1 until synced buffer_empty, then go to IDLE. Minimum 1 cycle.
- RESULT (1 cycle): tx_data = {result_valid, {(7-RESULT_W){0}}, result_reg}, pulse tx_load, clear result_valid, go to IDLE.
- A new IMG_TX clears result_valid.
- fsm_state encodings: IDLE=0, RX_CMD=1, DISPATCH=2, STATUS=3, IMG_RX=4, WAIT_INF=5, RESULT=6, CLEAR=7.
- Outputs are combinational from registered state; tx_data is registered.
- rst asserted mid-image returns to IDLE next edge. The buffer itself is not cleared by rst.

Decomposition:
- Package bnn_ctrl_pkg: state enum (4-bit), default command codes, err_flags bit indices.
- Sub-module sync_edge (parameter SYNC_STAGES): one synchroniser with registered rise/fall outputs, instantiated once per async input.

Test Plan:
- cs low, byte 8'hFE → STATUS.
  - One tx_load within SYNC_STAGES+3 cycles.
  - tx_data[1:0] = 2'b01, err bits 0.
  - Return to IDLE.
- IMG_TX with IMG_BYTES=113, 113 byte edges, buffer not full → exactly 113 buffer_write_enable pulses; bnn_start rises the cycle after the last write.
- In WAIT_INF, drive result_ready=1 with result_out=4'd7, then buffer_empty=1 → clear_buffer asserted until then. A following CMD_RESULT yields tx_data = 8'h87, and a second read yields 8'h07.
- Byte 8'h12 → err_flags = 3'b010, state IDLE. Then CMD_CLEAR → err_flags = 0.
- IMG_TX, 50 bytes, then silence with TIMEOUT_CYCLES=64 → IDLE after 64 cycles, err[0] = 1. A separate run raises cs after 50 bytes → IDLE with no error.
- buffer_full held at byte 10 → no further writes, err[2] set, byte_taken still pulses; rst mid-stream → all outputs at reset values next cycle.
